// File: rtl/seg7_scan_mux_pkg.sv
// Shared widths and helpers for the seg7_scan_mux display driver.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package seg7_scan_mux_pkg;

    localparam int SEG7_W   = 7;
    localparam int NIBBLE_W = 4;

    typedef logic [SEG7_W-1:0]   seg7_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Segment order {g,f,e,d,c,b,a}. Outputs are active-low because the
    // display is common-anode: a segment lights when its cathode is pulled low.
    function automatic seg7_t hex_to_seg7(input nibble_t n);
        seg7_t lit;
        case (n)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // Pin level for an anode: 'on' is the logical enable, act_low flips it
    // for boards that switch anodes through PNP transistors.
    function automatic logic anode_level(input logic act_low, input logic on);
        return on ^ act_low;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_seg7sync.sv
// Seg7Sync: registered hex-nibble to 7-segment decoder.
// Latency: 1 clock from iv_nibble to ov_seg.
// Backpressure: none; decodes every cycle.
// Ports: i_clk, i_rst (sync, active-high), iv_nibble (4b), ov_seg (7b active-low {g..a}).
module Seg7Sync
    import seg7_scan_mux_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  nibble_t iv_nibble,
    output seg7_t   ov_seg
);

    seg7_t r_seg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= '0;
        end else begin
            r_seg <= hex_to_seg7(iv_nibble);
        end
    end

    assign ov_seg = r_seg;

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: double-buffered, time-multiplexed common-anode 7-segment driver.
// Latency: registered outputs, 1 clock behind the scan state; new data shows from the next frame.
// Backpressure: none; i_load is always accepted, i_enable=0 freezes the scan with anodes off.
// Ports: i_clk, i_rst (sync, active-high), i_enable, i_load, iv_value[4*DIGITS], iv_dp[DIGITS],
//        ov_seg[7], o_dp, ov_an[DIGITS] (one-hot, polarity ANODE_ACT_LOW), o_frame (wrap pulse).
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 1000,
    parameter bit ANODE_ACT_LOW = 1'b1,
    parameter bit BLANK_LZ      = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_load,
    input  logic [NIBBLE_W*DIGITS-1:0] iv_value,
    input  logic [DIGITS-1:0]          iv_dp,
    output logic [SEG7_W-1:0]          ov_seg,
    output logic                       o_dp,
    output logic [DIGITS-1:0]          ov_an,
    output logic                       o_frame
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0]     P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]     I_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ANODE_ACT_LOW}};

    logic [PW-1:0]                r_presc;
    logic [IW-1:0]                r_idx;
    logic [NIBBLE_W*DIGITS-1:0]   r_pend_val;
    logic [DIGITS-1:0]            r_pend_dp;
    logic [NIBBLE_W*DIGITS-1:0]   r_shad_val;
    logic [DIGITS-1:0]            r_shad_dp;
    logic [DIGITS-1:0]            r_an;
    logic                         r_dp;
    logic                         r_frame;
    logic                         r_frame_pend;

    logic                         w_slot_end;
    logic                         w_wrap;
    nibble_t                      w_nibble;
    logic                         w_cur_dp;
    logic                         w_cur_blank;
    logic [DIGITS-1:0]            w_blank;
    logic                         w_lz_run;
    logic                         w_lit;
    logic [DIGITS-1:0]            w_an_next;

    assign w_slot_end = i_enable && (r_presc == P_LAST);
    assign w_wrap     = w_slot_end && (r_idx == I_LAST);

    // Select the current digit's nibble, dp bit and blank flag from the shadow copy.
    always_comb begin
        w_nibble    = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == r_idx) begin
                w_nibble    = r_shad_val[k*NIBBLE_W +: NIBBLE_W];
                w_cur_dp    = r_shad_dp[k];
                w_cur_blank = w_blank[k];
            end
        end
    end

    // Leading-zero mask: walk down from the most significant digit while both
    // nibble and dp are zero. Digit 0 is never blanked so a value of 0 still shows.
    always_comb begin
        w_blank  = '0;
        w_lz_run = 1'b1;
        if (BLANK_LZ) begin
            for (int k = DIGITS - 1; k >= 1; k--) begin
                w_lz_run   = w_lz_run && (r_shad_val[k*NIBBLE_W +: NIBBLE_W] == '0)
                             && !r_shad_dp[k];
                w_blank[k] = w_lz_run;
            end
        end
    end

    // Prescaler value 0 is the dead cycle: the decoder is loading the new
    // digit, so the anode stays off to avoid ghosting the previous pattern.
    assign w_lit = i_enable && (r_presc != '0) && !w_cur_blank;

    always_comb begin
        w_an_next = AN_OFF;
        for (int k = 0; k < DIGITS; k++) begin
            w_an_next[k] = anode_level(ANODE_ACT_LOW, w_lit && (IW'(k) == r_idx));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_shad_val   <= '0;
            r_shad_dp    <= '0;
            r_an         <= AN_OFF;
            r_dp         <= 1'b0;
            r_frame      <= 1'b0;
            r_frame_pend <= 1'b0;
        end else begin
            r_an    <= w_an_next;
            r_dp    <= w_lit && w_cur_dp;
            // The frame pulse is emitted alongside digit 0's dead cycle, so it is
            // held pending across a disable that lands right on the wrap.
            r_frame <= i_enable && r_frame_pend;

            if (i_enable) begin
                r_frame_pend <= w_wrap;
                if (w_slot_end) begin
                    r_presc <= '0;
                    r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (i_load) begin
                r_pend_val <= iv_value;
                r_pend_dp  <= iv_dp;
            end

            // A load landing on the wrap cycle goes straight to the shadow copy.
            if (w_wrap) begin
                r_shad_val <= i_load ? iv_value : r_pend_val;
                r_shad_dp  <= i_load ? iv_dp    : r_pend_dp;
            end
        end
    end

    Seg7Sync u_dec (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .iv_nibble (w_nibble),
        .ov_seg    (ov_seg)
    );

    assign ov_an   = r_an;
    assign o_dp    = r_dp;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Table-driven bench for seg7_scan_mux (DIGITS=4, PRESCALE=4, active-low anodes, blanking on).
// Latency: each vector is driven, one clock elapses, outputs are sampled 1 time unit after the edge.
// Backpressure: not applicable.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .DIGITS        (4),
        .PRESCALE      (4),
        .ANODE_ACT_LOW (1'b1),
        .BLANK_LZ      (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (en),
        .i_load   (load),
        .iv_value (val),
        .iv_dp    (dpi),
        .ov_seg   (seg),
        .o_dp     (dp),
        .ov_an    (an),
        .o_frame  (frame)
    );

    // Reference asynchronous decoder, active-low {g..a}.
    function automatic logic [6:0] seg7_async(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    typedef struct {
        logic        rst;
        logic        en;
        logic        load;
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [3:0]  an;
        logic [6:0]  seg;
        bit          chk_seg;
        logic        dp;
        logic        frame;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic add_reset_row();
        vec_t v;
        v = '{rst: 1'b1, en: 1'b0, load: 1'b0, val: 16'h0, dpi: 4'h0,
              an: 4'hF, seg: 7'h00, chk_seg: 1'b1, dp: 1'b0, frame: 1'b0};
        tbl.push_back(v);
    endtask

    // One 16-cycle frame in output time, starting at digit 0's dead cycle.
    // blank_hand is the hand-worked set of leading-zero-suppressed digits.
    task automatic add_frame(input logic [15:0] shown, input logic [3:0] shown_dp,
                             input logic [3:0] blank_hand, input bit pulse,
                             input int load_row, input logic [15:0] lval,
                             input logic [3:0] ldp);
        vec_t v;
        bit   lit;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                lit       = (p != 0) && !blank_hand[d];
                v.rst     = 1'b0;
                v.en      = 1'b1;
                v.load    = ((d*4 + p) == load_row);
                v.val     = v.load ? lval : 16'h0;
                v.dpi     = v.load ? ldp : 4'h0;
                v.an      = lit ? ~(4'b0001 << d) : 4'hF;
                v.seg     = seg7_async(shown[d*4 +: 4]);
                v.chk_seg = lit;
                v.dp      = lit ? shown_dp[d] : 1'b0;
                v.frame   = pulse && (d == 0) && (p == 0);
                tbl.push_back(v);
            end
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame && n < 40);
    endtask

    int n;

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; val = 16'h0; dpi = 4'h0;

        add_reset_row();
        add_reset_row();
        // Frame 0 still shows the reset shadow (0); 12AB goes to pending.
        add_frame(16'h0000, 4'h0, 4'b1110, 1'b0, 0,  16'h12AB, 4'b0000);
        // Mid-frame load of 0005 must not disturb the 12AB frame.
        add_frame(16'h12AB, 4'h0, 4'b0000, 1'b1, 3,  16'h0005, 4'b0000);
        add_frame(16'h0005, 4'h0, 4'b1110, 1'b1, 7,  16'h1111, 4'b0000);
        add_frame(16'h1111, 4'h0, 4'b0000, 1'b1, 6,  16'h2222, 4'b0100);
        // Load on the wrap cycle itself bypasses pending into the next frame.
        add_frame(16'h2222, 4'b0100, 4'b0000, 1'b1, 15, 16'h0003, 4'b0010);
        // dp on digit 1 stops blanking at digit 1; digits 2,3 still blank.
        add_frame(16'h0003, 4'b0010, 4'b1100, 1'b1, -1, 16'h0000, 4'b0000);

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            en   = tbl[i].en;
            load = tbl[i].load;
            val  = tbl[i].val;
            dpi  = tbl[i].dpi;
            tick();
            vectors++;
            if ({an, dp, frame} !== {tbl[i].an, tbl[i].dp, tbl[i].frame}) begin
                miscompares++;
                $display("FAIL row%0d an/dp/frame got=%b/%b/%b expected=%b/%b/%b",
                         i, an, dp, frame, tbl[i].an, tbl[i].dp, tbl[i].frame);
            end
            if (tbl[i].chk_seg) begin
                vectors++;
                if (seg !== tbl[i].seg) begin
                    miscompares++;
                    $display("FAIL row%0d seg got=%h expected=%h", i, seg, tbl[i].seg);
                end
            end
        end

        // Frame period and enable-gap behaviour.
        load = 1'b1; val = 16'h4321; dpi = 4'h0;
        tick();
        load = 1'b0; val = 16'h0;
        chk("frame_after_table", {31'd0, frame}, 32'd1);
        wait_frame(n);
        chk("frame_period_16", n, 16);
        repeat (5) tick();
        chk("d1_lit_an", {28'd0, an}, {28'd0, 4'b1101});
        chk("d1_lit_seg", {25'd0, seg}, {25'd0, seg7_async(4'h2)});
        en = 1'b0;
        tick();
        chk("disable_an_off", {28'd0, an}, {28'd0, 4'hF});
        chk("disable_dp_zero", {31'd0, dp}, 32'd0);
        repeat (4) tick();
        en = 1'b1;
        tick();
        chk("resume_an", {28'd0, an}, {28'd0, 4'b1101});
        chk("resume_seg", {25'd0, seg}, {25'd0, seg7_async(4'h2)});
        wait_frame(n);
        chk("frame_after_gap", n, 10);

        // Reset in the middle of digit 2's slot.
        repeat (9) tick();
        chk("d2_lit_an", {28'd0, an}, {28'd0, 4'b1011});
        chk("d2_lit_seg", {25'd0, seg}, {25'd0, seg7_async(4'h3)});
        rst = 1'b1;
        tick();
        chk("rst_an", {28'd0, an}, {28'd0, 4'hF});
        chk("rst_seg_dp_frame", {23'd0, seg, dp, frame}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_dead", {28'd0, an}, {28'd0, 4'hF});
        tick();
        chk("post_rst_d0_an", {28'd0, an}, {28'd0, 4'b1110});
        chk("post_rst_d0_seg", {25'd0, seg}, {25'd0, seg7_async(4'h0)});
        wait_frame(n);
        chk("post_rst_first_frame", n, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
